// File: rtl/queue_structure.sv
// Circular-buffer FIFO with pop, non-destructive peak, registered read data and sticky
// overflow/underflow flags.
module queue_structure #(
    parameter int data_width  = 8,
    parameter int QUEUE_depth = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         peak,
    input  logic [data_width-1:0]        dataIn,
    output logic [data_width-1:0]        dataOut,
    output logic                         out_valid,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(QUEUE_depth):0] count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(QUEUE_depth);
    localparam int CW = AW + 1;

    logic [data_width-1:0] mem [QUEUE_depth];
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [CW-1:0]         cnt;

    logic do_wr;
    logic do_rd;
    logic do_peek;
    logic set_ovf;
    logic set_unf;

    assign count = cnt;
    assign full  = (cnt == CW'(QUEUE_depth));
    assign empty = (cnt == '0);

    always_comb begin
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        do_peek = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        // peak combined with push or pop is deliberately ignored
        if (!(peak && (push || pop))) begin
            if (push && pop) begin
                // when full, the pop frees the slot the push lands in
                do_wr = 1'b1;
                if (empty) set_unf = 1'b1;
                else       do_rd   = 1'b1;
            end else if (push) begin
                if (full) set_ovf = 1'b1;
                else      do_wr   = 1'b1;
            end else if (pop) begin
                if (empty) set_unf = 1'b1;
                else       do_rd   = 1'b1;
            end else if (peak) begin
                if (empty) set_unf = 1'b1;
                else       do_peek = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            dataOut   <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= do_rd | do_peek;
            if (do_rd || do_peek) dataOut <= mem[head];
            if (do_rd) head <= head + AW'(1);
            if (do_wr) tail <= tail + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            overflow  <= overflow | set_ovf;
            underflow <= underflow | set_unf;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_wr && !rst) mem[tail] <= dataIn;
    end

endmodule

// File: tb/tb_queue_structure.sv
// Self-checking bench for queue_structure: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_queue_structure;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    logic          peak;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;
    logic          out_valid;
    logic          full;
    logic          empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_unf;

    queue_structure #(
        .data_width (DW),
        .QUEUE_depth(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .peak     (peak),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .out_valid(out_valid),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic model_step(input logic pu, input logic po, input logic pk,
                              input logic [DW-1:0] d);
        exp_valid = 1'b0;
        if (pk && (pu || po)) begin
        end else if (pu && po) begin
            if (q.size() == 0) begin
                q.push_back(d);
                exp_unf = 1'b1;
            end else begin
                exp_dout  = q.pop_front();
                exp_valid = 1'b1;
                q.push_back(d);
            end
        end else if (pu) begin
            if (q.size() < DEPTH) q.push_back(d);
            else                  exp_ovf = 1'b1;
        end else if (po) begin
            if (q.size() > 0) begin
                exp_dout  = q.pop_front();
                exp_valid = 1'b1;
            end else begin
                exp_unf = 1'b1;
            end
        end else if (pk) begin
            if (q.size() > 0) begin
                exp_dout  = q[0];
                exp_valid = 1'b1;
            end else begin
                exp_unf = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dataOut"}, 32'(dataOut), 32'(exp_dout));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
    endtask

    // Drive one command across one rising edge, then check 1 time unit later.
    task automatic step(input string tag, input logic pu, input logic po, input logic pk,
                        input logic [DW-1:0] d);
        push   = pu;
        pop    = po;
        peak   = pk;
        dataIn = d;
        @(posedge clk);
        #1;
        model_step(pu, po, pk, d);
        check_all(tag);
        push = 1'b0;
        pop  = 1'b0;
        peak = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          pu, po, pk;

        rst    = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        peak   = 1'b0;
        dataIn = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Basic FIFO ordering
        step("p11", 1, 0, 0, 8'h11);
        step("p22", 1, 0, 0, 8'h22);
        step("p33", 1, 0, 0, 8'h33);
        step("pop1", 0, 1, 0, 8'h00);
        chk("pop1.lit", 32'(dataOut), 32'h11);
        step("pop2", 0, 1, 0, 8'h00);
        chk("pop2.lit", 32'(dataOut), 32'h22);
        step("pop3", 0, 1, 0, 8'h00);
        chk("pop3.lit", 32'(dataOut), 32'h33);
        chk("drain.empty", 32'(empty), 32'h1);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, DW'(i));
        chk("fill.full", 32'(full), 32'h1);
        step("ovf", 1, 0, 0, 8'hAA);
        chk("ovf.flag", 32'(overflow), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain8", 0, 1, 0, 8'h00);
            chk("drain8.lit", 32'(dataOut), 32'(i));
        end

        // Underflow, push+pop on empty, peak
        model_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step("unf.pop", 0, 1, 0, 8'h00);
        step("pp.empty", 1, 1, 0, 8'h5C);
        chk("pp.empty.valid", 32'(out_valid), 32'h0);
        step("peak5c", 0, 0, 1, 8'h00);
        chk("peak5c.lit", 32'(dataOut), 32'h5C);
        step("pop5c", 0, 1, 0, 8'h00);

        // Push+pop on full queue, then wrap-around
        for (int i = 0; i < DEPTH; i++) step("fill2", 1, 0, 0, DW'(i));
        step("pp.full", 1, 1, 0, 8'h99);
        chk("pp.full.lit", 32'(dataOut), 32'h00);
        for (int i = 1; i < DEPTH; i++) step("wrap", 0, 1, 0, 8'h00);
        step("wrap99", 0, 1, 0, 8'h00);
        chk("wrap99.lit", 32'(dataOut), 32'h99);

        // Peak twice, then peak+pop no-op
        step("p42", 1, 0, 0, 8'h42);
        step("peakA", 0, 0, 1, 8'h00);
        step("peakB", 0, 0, 1, 8'h00);
        step("peakpop", 0, 1, 1, 8'h00);
        step("peakpush", 1, 0, 1, 8'h77);
        step("idle", 0, 0, 0, 8'h00);

        // Asynchronous reset between edges, with a command held across the reset edge
        for (int i = 0; i < DEPTH + 1; i++) step("fill3", 1, 0, 0, DW'(8'h30 + i));
        step("peak30", 0, 0, 1, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        push   = 1'b1;
        dataIn = 8'hEE;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        check_all("rst.hold");
        step("post_rst.pop", 0, 1, 0, 8'h00);
        chk("post_rst.unf", 32'(underflow), 32'h1);

        // Random traffic
        model_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            pk = ($urandom_range(0, 99) < 15);
            d  = DW'($urandom);
            step("rand", pu, po, pk, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
